simplebus_arbiter: RTL
======================

Name: simplebus_arbiter

Overview:
Leader-side arbiter and sequencer for the 8-bit multiplexed simple bus. It shares one bus leader port between N requester threads, which may be processors or DMA engines. The winner is picked round-robin and its 16-bit-address read or write is run through the bus phases: start with upper address, then lower address with read, then data with dataValid. It sits between requester logic and the bus tri-state drivers; memory-side followers are unchanged.

Parameters:
N, 2, number of requesters (2..8)
TIMEOUT, 16, max cycles waiting for follower dataValid on a read; 0 disables the timeout
IDXW, $clog2(N) (min 1), width of the grant index

Ports:
clock  input  1  bus clock, all state on posedge
resetN  input  1  asynchronous active-low reset
req  input  N  per-requester access request; held high until done[i]
we  input  N  per-requester 1=write, 0=read; stable while req[i] is high
addr  input  16*N  per-requester address; slice i = addr[16*i+15:16*i]
wdata  input  8*N  per-requester write data; slice i = wdata[8*i+7:8*i]
gnt  output  N  one-cycle pulse: request accepted
done  output  N  one-cycle pulse: transaction finished
rdata  output  8  read data; valid while done[i] is high for a read
err  output  1  high with done when a read timed out
bus_start  output  1  bus start strobe
bus_read  output  1  bus read strobe
bus_address  output  8  address byte; the top level drives the tri bus from this when bus_addr_oe=1
bus_addr_oe  output  1  address bus enable
bus_data_out  output  8  write data onto the bus
bus_data_oe  output  1  data bus enable
bus_data_in  input  8  resolved bus data
bus_dv_out  output  1  dataValid driven by the leader
bus_dv_oe  output  1  dataValid enable
bus_dv_in  input  1  resolved dataValid

Behaviour:
- Clocking and reset: one clock `clock`; reset `resetN` is asynchronous, active-low.
- Reset state:
  - state=IDLE, rr_ptr=N-1.
  - gnt, done, err, bus_start, bus_read, bus_addr_oe, bus_data_oe, bus_dv_oe and bus_dv_out all 0; rdata=0.
- Mid-transaction reset: aborts immediately and releases all enables. No done is issued for the aborted transaction.
- States: IDLE, AHI, ALO, WDAT, RWAIT. All bus outputs decode from registered state and latched registers; no combinational path from req to the bus.
- IDLE:
  - If any req[i] is high: pick the first high requester searching from rr_ptr+1 upward, wrapping modulo N.
  - On the clock edge: latch idx, we[idx], addr slice and wdata slice; set rr_ptr=idx; gnt[idx]=1 for the next cycle; go to AHI.
  - If no requester is high, the state stays IDLE.
- AHI (1 cycle): bus_start=1, bus_addr_oe=1, bus_address=A[15:8]; then go to ALO.
- ALO (1 cycle): bus_addr_oe=1, bus_address=A[7:0], bus_read=~WE; then go to WDAT if WE, else RWAIT.
- WDAT (1 cycle): bus_data_oe=1, bus_data_out=D, bus_dv_oe=1, bus_dv_out=1; then go to IDLE with done[idx]=1 next cycle.
- RWAIT: all enables 0, timeout counter incrementing.
  - On an edge with bus_dv_in=1: rdata<=bus_data_in, done[idx]=1, err=0, go to IDLE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no dataValid: done[idx]=1, err=1, rdata unchanged, go to IDLE.
  - dataValid on the same edge as the timeout wins: treated as a normal completion.
- Latency from the IDLE accept edge to done:
  - Write: done is high in the 4th cycle after accept.
  - Read: done is high 1 cycle after the dataValid edge.
- Turnaround: at least one IDLE cycle (the done cycle) between transactions. The next bus_start appears no earlier than 2 cycles after done.
- Requester drops req[i] before done: ignored; the transaction completes and done still pulses.
- req[i] still high in the done cycle: it is eligible again, but round-robin gives other requesters priority first.
- Only one gnt and one done bit may be high in any cycle.
- Never more than one of bus_addr_oe, bus_data_oe is high; bus_dv_oe is only high in WDAT.

Test Plan:
- Reset: hold resetN=0 with req=2'b11 -> all outputs 0. Release; first grant goes to requester 0 (rr_ptr=N-1).
- Single write: req[0], we=1, addr=16'h0406, wdata=8'hDC -> gnt[0]. Then bus_start=1 with address 8'h04; next cycle address 8'h06 with read=0; next cycle data 8'hDC with dv=1; then done[0]. The memory model stores 8'hDC at 0406.
- Single read: req[1], we=0, addr=16'h0406; follower asserts dv with data 8'hDC after 3 cycles -> read=1 in the ALO cycle, rdata=8'hDC with done[1] and err=0.
- Contention: req=2'b11 held continuously, requester 0 writes 0407/AB, requester 1 reads 0406 -> grants alternate 0,1,0,1. Each transaction completes before the next bus_start.
- Timeout: read with the follower never asserting dv, TIMEOUT=16 -> done and err=1 exactly 16 cycles after entering RWAIT. The bus stays released, and the next request is serviced normally.
- Mid-op reset: pull resetN low during WDAT -> bus_data_oe and bus_dv_oe drop asynchronously with no done. After release, the pending req is re-granted from IDLE.

Source files
------------

// File: rtl/simplebus_arbiter.sv
// Round-robin leader arbiter for the 8-bit multiplexed simple bus.
// Runs the winner's read/write through the address-high, address-low and data phases.
module simplebus_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned IDXW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      we,
    input  logic [16*N-1:0]   addr,
    input  logic [8*N-1:0]    wdata,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              bus_start,
    output logic              bus_read,
    output logic [7:0]        bus_address,
    output logic              bus_addr_oe,
    output logic [7:0]        bus_data_out,
    output logic              bus_data_oe,
    input  logic [7:0]        bus_data_in,
    output logic              bus_dv_out,
    output logic              bus_dv_oe,
    input  logic              bus_dv_in
);

    localparam int unsigned CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StAhi,
        StAlo,
        StWdat,
        StRwait
    } state_e;

    state_e            r_state;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_idx;
    logic              r_we;
    logic [15:0]       r_addr;
    logic [7:0]        r_wdata;
    logic [N-1:0]      r_gnt;
    logic [N-1:0]      r_done;
    logic              r_err;
    logic [7:0]        r_rdata;
    logic [CNTW-1:0]   r_cnt;

    state_e            w_state_nxt;
    logic [IDXW-1:0]   w_rr_nxt;
    logic [IDXW-1:0]   w_idx_nxt;
    logic              w_we_nxt;
    logic [15:0]       w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic [N-1:0]      w_gnt_nxt;
    logic [N-1:0]      w_done_nxt;
    logic              w_err_nxt;
    logic [7:0]        w_rdata_nxt;
    logic [CNTW-1:0]   w_cnt_nxt;

    logic              w_found;
    logic [IDXW-1:0]   w_pick;
    int                w_cand;
    logic [15:0]       w_addr_sel;
    logic [7:0]        w_wdata_sel;
    logic              w_we_sel;

    // Round-robin search starting just after the last winner, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = 0;
        for (int k = 1; k <= int'(N); k++) begin
            w_cand = (int'(r_rr_ptr) + k) % int'(N);
            if (!w_found && req[IDXW'(w_cand)]) begin
                w_found = 1'b1;
                w_pick  = IDXW'(w_cand);
            end
        end
    end

    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_pick == IDXW'(i)) begin
                w_addr_sel  = addr[16*i +: 16];
                w_wdata_sel = wdata[8*i +: 8];
            end
        end
        w_we_sel = we[w_pick];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_idx_nxt   = r_idx;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = '0;
        unique case (r_state)
            StIdle: begin
                // The done cycle is never an accept cycle, forcing bus turnaround.
                if (w_found && (r_done == '0)) begin
                    w_idx_nxt   = w_pick;
                    w_rr_nxt    = w_pick;
                    w_we_nxt    = w_we_sel;
                    w_addr_nxt  = w_addr_sel;
                    w_wdata_nxt = w_wdata_sel;
                    w_gnt_nxt   = ONE << w_pick;
                    w_state_nxt = StAhi;
                end
            end
            StAhi: w_state_nxt = StAlo;
            StAlo: w_state_nxt = r_we ? StWdat : StRwait;
            StWdat: begin
                w_done_nxt  = ONE << r_idx;
                w_state_nxt = StIdle;
            end
            StRwait: begin
                if (bus_dv_in) begin
                    w_rdata_nxt = bus_data_in;
                    w_done_nxt  = ONE << r_idx;
                    w_state_nxt = StIdle;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    w_done_nxt  = ONE << r_idx;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state  <= StIdle;
            r_rr_ptr <= IDXW'(N - 1);
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_idx    <= w_idx_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_rdata  <= w_rdata_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Bus phase outputs decode only from registered state, never from req.
    always_comb begin
        bus_start    = 1'b0;
        bus_read     = 1'b0;
        bus_address  = '0;
        bus_addr_oe  = 1'b0;
        bus_data_out = '0;
        bus_data_oe  = 1'b0;
        bus_dv_out   = 1'b0;
        bus_dv_oe    = 1'b0;
        case (r_state)
            StAhi: begin
                bus_start   = 1'b1;
                bus_addr_oe = 1'b1;
                bus_address = r_addr[15:8];
            end
            StAlo: begin
                bus_addr_oe = 1'b1;
                bus_address = r_addr[7:0];
                bus_read    = ~r_we;
            end
            StWdat: begin
                bus_data_oe  = 1'b1;
                bus_data_out = r_wdata;
                bus_dv_oe    = 1'b1;
                bus_dv_out   = 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule
